// File: rtl/mod17_result_fifo.sv
// First-word-fall-through result FIFO behind divident_mod17, with sticky overflow / range flags.
// Optional value check compiled in with `define MOD17_FIFO_RANGE_CHK_EN.
module mod17_result_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mark_in,
    input  logic [4:0]        reminder_in,
    input  logic              out_ready,
    input  logic              clear_ovf,
    output logic              out_valid,
    output logic [4:0]        reminder_out,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              range_err
);

    localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];

    logic [4:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   level_nxt;
    logic              pop;
    logic              push_req;
    logic              push;
    logic              range_bad;
    logic              ovf_set;

`ifdef MOD17_FIFO_RANGE_CHK_EN
    assign range_bad = mark_in && (reminder_in > 5'd16);
`else
    assign range_bad = 1'b0;
`endif

    assign out_valid    = !empty;
    assign reminder_out = out_valid ? mem[rd_ptr] : 5'd0;
    assign pop          = out_valid && out_ready;
    assign push_req     = mark_in && !range_bad;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push         = push_req && (!full || pop);
    assign ovf_set      = mark_in && full && !pop;

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + 1'b1;
        else if (pop && !push)
            level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= reminder_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == FULL_LVL);
            empty <= (level_nxt == '0);
        end
    end

    // Set has priority over clear so a drop in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (ovf_set)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
            if (range_bad)
                range_err <= 1'b1;
            else if (clear_ovf)
                range_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod17_result_fifo.sv
// Directed bench for mod17_result_fifo; checks follow the active macro MOD17_FIFO_RANGE_CHK_EN.
module tb_mod17_result_fifo;

    logic       clk;
    logic       rst_n;
    logic       mark_in;
    logic [4:0] reminder_in;
    logic       out_ready;
    logic       clear_ovf;
    logic       out_valid;
    logic [4:0] reminder_out;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       range_err;

    int vectors = 0;
    int miscompares = 0;
    int q[$];

    mod17_result_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mark_in(mark_in),
        .reminder_in(reminder_in),
        .out_ready(out_ready),
        .clear_ovf(clear_ovf),
        .out_valid(out_valid),
        .reminder_out(reminder_out),
        .level(level),
        .full(full),
        .empty(empty),
        .overflow(overflow),
        .range_err(range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        mark_in = 1'b0;
        reminder_in = 5'd0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        #12;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(reminder_out), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_rerr", int'(range_err), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // fill with 0..16; the 17th is dropped
        for (int i = 0; i < 17; i++) begin
            mark_in = 1'b1;
            reminder_in = 5'(i);
            tick();
            chk("fill_level", int'(level), (i < 16) ? i + 1 : 16);
            chk("fill_full", int'(full), (i >= 15) ? 1 : 0);
            chk("fill_ovf", int'(overflow), (i == 16) ? 1 : 0);
        end
        mark_in = 1'b0;
        chk("fill_head", int'(reminder_out), 0);
        chk("fill_valid", int'(out_valid), 1);

        // clear together with a full-drop: set wins
        mark_in = 1'b1;
        reminder_in = 5'd9;
        clear_ovf = 1'b1;
        tick();
        chk("clr_drop_ovf", int'(overflow), 1);
        chk("clr_drop_level", int'(level), 16);
        mark_in = 1'b0;
        tick();
        chk("clr_alone_ovf", int'(overflow), 0);
        clear_ovf = 1'b0;

        // full with simultaneous pop and push of 5
        out_ready = 1'b1;
        mark_in = 1'b1;
        reminder_in = 5'd5;
        tick();
        mark_in = 1'b0;
        out_ready = 1'b0;
        chk("fullpp_level", int'(level), 16);
        chk("fullpp_full", int'(full), 1);
        chk("fullpp_ovf", int'(overflow), 0);
        chk("fullpp_head", int'(reminder_out), 1);

        // drain: 1..15 then 5
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", int'(reminder_out), (i < 15) ? i + 1 : 5);
            chk("drain_valid", int'(out_valid), 1);
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", int'(empty), 1);
        chk("drain_valid0", int'(out_valid), 0);
        chk("drain_data0", int'(reminder_out), 0);
        chk("drain_level", int'(level), 0);

        // 40 back-to-back push+pop; pointers wrap
        q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            mark_in = 1'b1;
            reminder_in = 5'(i % 17);
            if (q.size() != 0) begin
                chk("stream_pre", int'(reminder_out), q[0]);
                void'(q.pop_front());
            end
            q.push_back(i % 17);
            tick();
            chk("stream_level", int'(level), 1);
            chk("stream_head", int'(reminder_out), q[0]);
        end
        mark_in = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("stream_empty", int'(empty), 1);

        // out-of-range value followed by 3
        mark_in = 1'b1;
        reminder_in = 5'd20;
        tick();
        reminder_in = 5'd3;
        tick();
        mark_in = 1'b0;
`ifdef MOD17_FIFO_RANGE_CHK_EN
        chk("range_err", int'(range_err), 1);
        chk("range_level", int'(level), 1);
        chk("range_head", int'(reminder_out), 3);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("range_clr", int'(range_err), 0);
        out_ready = 1'b1;
        tick();
`else
        chk("range_err", int'(range_err), 0);
        chk("range_level", int'(level), 2);
        chk("range_head", int'(reminder_out), 20);
        out_ready = 1'b1;
        tick();
        chk("range_head2", int'(reminder_out), 3);
        tick();
`endif
        out_ready = 1'b0;
        chk("range_empty", int'(empty), 1);

        // overflow, then drain to level 7 and reset asynchronously
        for (int i = 0; i < 17; i++) begin
            mark_in = 1'b1;
            reminder_in = 5'(i);
            tick();
        end
        mark_in = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        out_ready = 1'b0;
        chk("pre_rst_level", int'(level), 7);
        chk("pre_rst_ovf", int'(overflow), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_level", int'(level), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_ovf", int'(overflow), 0);
        chk("arst_rerr", int'(range_err), 0);
        chk("arst_full", int'(full), 0);
        tick();

        // push accepted on the first edge after release
        rst_n = 1'b1;
        mark_in = 1'b1;
        reminder_in = 5'd11;
        tick();
        mark_in = 1'b0;
        chk("rel_level", int'(level), 1);
        chk("rel_head", int'(reminder_out), 11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod17_result_fifo.md
# mod17_result_fifo

Downstream stage of `divident_mod17`. It captures the unthrottled `mark_out`/`reminder` result stream into a first-word-fall-through FIFO and presents it to a consumer over a valid/ready handshake. `divident_mod17` cannot be stalled, so this block absorbs bursts, reports fill level, and flags overflow when results are lost.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `ADDR_W`, 4, pointer width; must equal log2(`DEPTH`).

Ports (clock and reset first):
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mark_in` in 1: result strobe, driven by `divident_mod17.mark_out`.
- `reminder_in` in 5: remainder value, driven by `divident_mod17.reminder`; the legal range is 0..16.
- `out_ready` in 1: the consumer accepts the head entry.
- `clear_ovf` in 1: synchronous clear of the sticky error flags.
- `out_valid` out 1: the head entry is valid.
- `reminder_out` out 5: the head entry value.
- `level` out ADDR_W+1: number of stored entries, 0..`DEPTH`.
- `full` out 1: `level == DEPTH`.
- `empty` out 1: `level == 0`.
- `overflow` out 1: sticky flag; a result was dropped because the FIFO was full.
- `range_err` out 1: sticky flag; a value greater than 16 was received (only when the check is compiled in).

## Operation
- Storage: register array of `DEPTH`×5 bits. Read pointer and write pointer are ADDR_W bits each and wrap modulo `DEPTH`. `level` is a separate ADDR_W+1-bit counter.
- Push condition: `mark_in == 1` and the entry is accepted (rules below).
- Pop condition: `out_valid && out_ready`.
- Accept rule: a push is accepted if `!full`, or if `full` and a pop occurs in the same cycle.
- Full rule: if `full` and no pop occurs, the incoming result is dropped and `overflow` is set.
- Level update:
  - push only: `level` +1.
  - pop only: `level` −1.
  - push and pop in the same cycle: `level` is unchanged; both pointers advance.
- Empty FIFO: `out_valid` = 0 and `out_ready` is ignored. No bypass: a push into an empty FIFO is not visible on the output in the same cycle.
- Head output: `reminder_out` = `mem[rd_ptr]` when `out_valid` = 1, and 0 otherwise.
- Sticky flags:
  - `overflow` and `range_err` hold until `clear_ovf` is asserted or reset occurs.
  - If a set event and `clear_ovf` occur in the same cycle, set wins.
- `mark_in == 0`: `reminder_in` is ignored.
- Reset is asynchronous: pointers, `level`, and flags clear immediately. Stored contents are discarded; the memory array itself is not reset.

## Timing
- Reset values: `out_valid` 0, `reminder_out` 0, `level` 0, `full` 0, `empty` 1, `overflow` 0, `range_err` 0.
- Write-to-read latency: a push sampled at edge N makes `out_valid` = 1 and `reminder_out` valid in the cycle after edge N.
- A pop at edge N presents the next entry (or `out_valid` = 0) immediately after edge N.
- `level`, `full`, and `empty` are registered and reflect all pushes and pops of the preceding edge.
- Throughput: one push and one pop per cycle, sustained indefinitely at any `level`.
- Pointer wrap from `DEPTH`−1 to 0 has no bubble.
- Deassertion of `rst_n` takes effect at the first rising edge after release. `mark_in` during that edge is accepted normally.

## Configuration
- Macro: `MOD17_FIFO_RANGE_CHK_EN`.
- Defined:
  - `reminder_in` > 16 with `mark_in` = 1 is dropped (not stored) and sets `range_err`.
  - If that same cycle also hits the full-drop condition, both `range_err` and `overflow` set.
- Undefined:
  - Every value is stored unchecked.
  - `range_err` is tied to 0.

## Test plan
- Reset, then push 17 results with values 0,1,…,16 on consecutive cycles while `out_ready` = 0 and `DEPTH` = 16. Required: `level` reaches 16 and `full` = 1; value 16 is dropped and `overflow` = 1. Then drain with `out_ready` = 1 → `reminder_out` sequence 0..15, then `empty` = 1.
- With `full` = 1, hold `out_ready` = 1 and `mark_in` = 1 with value 5 for one cycle. Required: the head is popped, 5 is accepted, `level` stays 16, and `overflow` is unchanged.
- Drive 40 continuous pushes and pops with value `i % 17`. Required: `reminder_out` matches a reference queue with one-cycle latency, `level` stays 1 after the first push, and the pointers wrap twice without error.
- Pulse `clear_ovf` in the same cycle as a full-drop. Required: `overflow` stays 1. Pulse `clear_ovf` alone → `overflow` = 0.
- With `MOD17_FIFO_RANGE_CHK_EN` defined, push value 20 and then value 3. Required: `range_err` = 1, `level` = 1, head = 3. With the macro undefined, the same stimulus gives head 20, then 3, and `range_err` = 0.
- Assert `rst_n` = 0 mid-stream with `level` = 7. Required: `level` = 0, `empty` = 1, `out_valid` = 0, and the flags clear immediately, without waiting for a clock edge.
